// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock async FIFO pointer blocks (write and read side).
// Gray/binary helpers work on a 32-bit container; callers zero-extend and truncate to width.
package async_fifo_pkg;

  localparam int unsigned ASIZE_DFLT = 4;
  localparam int unsigned DEPTH      = 1 << ASIZE_DFLT;

  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return (x >> 1) ^ x;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] x);
    logic [31:0] b;
    b = x;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ x[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter built as an MSB-first XOR prefix chain.
module fifo_gray2bin #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] bin_o
);

  always_comb begin
    bin_o = gray_i;
    for (int i = int'(Width) - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, RAM write port control and full/overflow flags of the async FIFO.
// Optional occupancy estimate and almost-full flag are enabled by ASYNC_FIFO_WLEVEL_EN.
module fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int unsigned ASIZE        = ASIZE_DFLT,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             woverflow_clr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             woverflow,
  output logic [ASIZE:0]   wlevel,
  output logic             walmost_full
);

  if (ASIZE < 2) begin : g_bad_asize
    $error("fifo_wptr_full: ASIZE must be >= 2");
  end
  if (AFULL_MARGIN > (1 << ASIZE)) begin : g_bad_margin
    $error("fifo_wptr_full: AFULL_MARGIN exceeds FIFO depth");
  end

  logic [ASIZE:0] wbin_q, wbin_next, wgray_next, wptr_q;
  logic           wfull_q, wfull_next;
  logic           woverflow_q, woverflow_d;

  assign wen        = winc & ~wfull_q;
  assign wbin_next  = wbin_q + {{ASIZE{1'b0}}, wen};
  assign wgray_next = (ASIZE + 1)'(bin2gray(32'(wbin_next)));

  // Full when the next write pointer has lapped the read pointer: top two Gray bits inverted.
  assign wfull_next = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

  // A write attempt while full sets the flag even if a clear arrives in the same cycle.
  always_comb begin
    woverflow_d = woverflow_q;
    if (woverflow_clr) woverflow_d = 1'b0;
    if (winc && wfull_q) woverflow_d = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_next;
      wptr_q      <= wgray_next;
      wfull_q     <= wfull_next;
      woverflow_q <= woverflow_d;
    end
  end

  assign waddr     = wbin_q[ASIZE-1:0];
  assign wptr      = wptr_q;
  assign wfull     = wfull_q;
  assign woverflow = woverflow_q;

`ifdef ASYNC_FIFO_WLEVEL_EN
  localparam logic [ASIZE:0] AfullLevel = (ASIZE + 1)'((1 << ASIZE) - AFULL_MARGIN);

  logic [ASIZE:0] rbin_s, wlevel_next, wlevel_q;
  logic           wafull_q;

  fifo_gray2bin #(
    .Width(ASIZE + 1)
  ) u_rptr_g2b (
    .gray_i(wq2_rptr),
    .bin_o (rbin_s)
  );

  // The synchronized read pointer lags, so this level can only over-estimate occupancy.
  assign wlevel_next = wbin_next - rbin_s;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      wafull_q <= 1'b0;
    end else begin
      wlevel_q <= wlevel_next;
      wafull_q <= (wlevel_next >= AfullLevel);
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = wafull_q;
`else
  assign wlevel       = '0;
  assign walmost_full = wfull_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full at ASIZE=4, AFULL_MARGIN=2.
module tb_fifo_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       woverflow_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       woverflow;
  logic [4:0] wlevel;
  logic       walmost_full;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(
    .ASIZE       (4),
    .AFULL_MARGIN(2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .woverflow_clr(woverflow_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .woverflow    (woverflow),
    .wlevel       (wlevel),
    .walmost_full (walmost_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    winc = 1'b0; woverflow_clr = 1'b0; wq2_rptr = 5'b00000;
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    winc = 1'b0; woverflow_clr = 1'b0; wq2_rptr = 5'b00000;
    wrst_n = 1'b0;
    #2;
    checks++; if (wptr !== 5'b00000) begin errors++; $display("FAIL reset_wptr got=%b want=00000", wptr); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got=%b want=0", wfull); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL reset_wovf got=%b want=0", woverflow); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel got=%0d want=0", wlevel); end
    step();
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (wptr !== 5'b00000 || waddr !== 4'd0 || wfull !== 1'b0 || woverflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got wptr=%b waddr=%0d wfull=%b wovf=%b want all 0",
               wptr, waddr, wfull, woverflow);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < int'(async_fifo_pkg::DEPTH); i++) begin
      winc = 1'b1;
      #1;
      checks++;
      if (waddr !== 4'(i) || wen !== 1'b1) begin
        errors++;
        $display("FAIL fill_addr[%0d] got waddr=%0d wen=%b want waddr=%0d wen=1", i, waddr, wen, i);
      end
      if (i == 15) begin
        checks++;
        if (wfull !== 1'b0) begin errors++; $display("FAIL fill_early_full got=%b want=0", wfull); end
      end
      step();
    end
    winc = 1'b0;
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", wfull); end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr got=%b want=11000", wptr); end
    checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL fill_afull got=%b want=1", walmost_full); end
  endtask

  task automatic test_overflow();
    winc = 1'b1;
    #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL ovf_wen got=%b want=0", wen); end
    step();
    winc = 1'b0;
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr got=%0d want=0", waddr); end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr got=%b want=11000", wptr); end
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", woverflow); end
    step();
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", woverflow); end
    woverflow_clr = 1'b1;
    step();
    woverflow_clr = 1'b0;
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b want=0", woverflow); end
    // Set and clear together: set must win.
    winc = 1'b1; woverflow_clr = 1'b1;
    step();
    winc = 1'b0; woverflow_clr = 1'b0;
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b want=1", woverflow); end
    woverflow_clr = 1'b1;
    step();
    woverflow_clr = 1'b0;
  endtask

  task automatic test_unfull();
    wq2_rptr = 5'b00001;
    step();
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL unfull got=%b want=0", wfull); end
    winc = 1'b1;
    step();
    winc = 1'b0;
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL refull got=%b want=1", wfull); end
    checks++; if (wptr !== 5'b11001) begin errors++; $display("FAIL refull_wptr got=%b want=11001", wptr); end
    checks++; if (waddr !== 4'd1) begin errors++; $display("FAIL refull_waddr got=%0d want=1", waddr); end
  endtask

  task automatic test_wrap();
    logic [4:0] p1, p2;
    do_reset();
    p1 = 5'b00000; p2 = 5'b00000;
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1;
      wq2_rptr = p2;
      #1;
      checks++;
      if (waddr !== 4'(i % 16) || wfull !== 1'b0) begin
        errors++;
        $display("FAIL wrap[%0d] got waddr=%0d wfull=%b want waddr=%0d wfull=0",
                 i, waddr, wfull, i % 16);
      end
      step();
      p2 = p1; p1 = wptr;
      if (i == 30) begin
        checks++;
        if (wptr !== 5'b10000) begin errors++; $display("FAIL wrap_g31 got=%b want=10000", wptr); end
      end
      if (i == 31) begin
        checks++;
        if (wptr !== 5'b00000) begin errors++; $display("FAIL wrap_g0 got=%b want=00000", wptr); end
      end
    end
    winc = 1'b0;
  endtask

  task automatic test_level();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      winc = 1'b1;
      step();
      if (i == 12) begin
`ifdef ASYNC_FIFO_WLEVEL_EN
        checks++;
        if (wlevel !== 5'd13 || walmost_full !== 1'b0) begin
          errors++;
          $display("FAIL level13 got wlevel=%0d afull=%b want 13/0", wlevel, walmost_full);
        end
`endif
      end
    end
    winc = 1'b0;
`ifdef ASYNC_FIFO_WLEVEL_EN
    checks++;
    if (wlevel !== 5'd14 || walmost_full !== 1'b1) begin
      errors++;
      $display("FAIL level14 got wlevel=%0d afull=%b want 14/1", wlevel, walmost_full);
    end
    wq2_rptr = 5'b00110;
    step();
    checks++;
    if (wlevel !== 5'd10 || walmost_full !== 1'b0) begin
      errors++;
      $display("FAIL level10 got wlevel=%0d afull=%b want 10/0", wlevel, walmost_full);
    end
`else
    checks++;
    if (wlevel !== 5'd0 || walmost_full !== wfull || wfull !== 1'b0) begin
      errors++;
      $display("FAIL level_off got wlevel=%0d afull=%b wfull=%b want 0/0/0",
               wlevel, walmost_full, wfull);
    end
`endif
  endtask

  task automatic test_midop_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    checks++; if (waddr !== 4'd9) begin errors++; $display("FAIL midop_pre got=%0d want=9", waddr); end
    wrst_n = 1'b0;
    #1;
    checks++;
    if (wptr !== 5'b0 || waddr !== 4'd0 || wfull !== 1'b0 || woverflow !== 1'b0 ||
        wlevel !== 5'd0 || walmost_full !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got wptr=%b waddr=%0d wfull=%b wovf=%b wlevel=%0d afull=%b want 0",
               wptr, waddr, wfull, woverflow, wlevel, walmost_full);
    end
    step();
    wrst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_unfull();
    test_wrap();
    test_level();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
